// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage controller for the 16-bit core.
// Latches fetched instructions into the ID pipeline register, splits them into
// opcode/one/two/three fields, classifies the immediate type, and inserts
// load-use bubbles. It also runs the IF->ID->EX valid/ready handshake and
// squashes ID on flush.
// Optional build macro: ID_STALL_PERF_EN adds a saturating stall_count output.
module id_issue_ctrl #(
  parameter int STALL_CYCLES = 1  // bubbles per load-use hazard, 1..7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        ex_ready,
  input  logic        ex_load_valid,
  input  logic [3:0]  ex_load_dest,
  output logic        id_valid,
  output logic [3:0]  id_opcode,
  output logic [3:0]  id_one,
  output logic [3:0]  id_two,
  output logic [3:0]  id_three,
  output logic [1:0]  imm_type
`ifdef ID_STALL_PERF_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [1:0] IMM_NONE = 2'b00;
  localparam logic [1:0] IMM_B    = 2'b01;
  localparam logic [1:0] IMM_C    = 2'b10;
  localparam logic [1:0] IMM_D    = 2'b11;

  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES);

  logic [1:0] state_reg, state_next;
  logic [2:0] bubble_reg, bubble_next;
  logic [3:0] opcode_reg, one_reg, two_reg, three_reg;
  logic [1:0] imm_reg;

  logic       reads_one, reads_two, reads_three;
  logic       hazard;
  logic       full_hazard;
  logic       capture;

  // Immediate class of an opcode; this also determines which fields are sources.
  function automatic logic [1:0] decode_imm(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1011:          decode_imm = IMM_B;
      4'b0100, 4'b0101, 4'b0110: decode_imm = IMM_C;
      4'b1100, 4'b1111:          decode_imm = IMM_D;
      default:                   decode_imm = IMM_NONE;
    endcase
  endfunction

  // Load-use hazard from the registered instruction's source registers.
  always_comb begin
    reads_one   = (imm_reg == IMM_B) || (imm_reg == IMM_C);
    reads_two   = (imm_reg == IMM_B) || (imm_reg == IMM_NONE);
    reads_three = (imm_reg == IMM_NONE);
    hazard      = ex_load_valid &&
                  ((reads_one   && (ex_load_dest == one_reg)) ||
                   (reads_two   && (ex_load_dest == two_reg)) ||
                   (reads_three && (ex_load_dest == three_reg)));
    full_hazard = (state_reg == ST_FULL) && hazard;
  end

  // Handshake outputs: ID is valid only when full and not blocked by a hazard.
  always_comb begin
    id_valid = (state_reg == ST_FULL) && !hazard;
    if_ready = 1'b0;
    case (state_reg)
      ST_EMPTY: if_ready = 1'b1;
      ST_FULL:  if_ready = !hazard && ex_ready;
      default:  if_ready = 1'b0;
    endcase
    capture = if_valid && if_ready && !flush;
  end

  // Next-state and bubble counter; flush overrides everything.
  always_comb begin
    state_next  = state_reg;
    bubble_next = bubble_reg;
    if (flush) begin
      state_next  = ST_EMPTY;
      bubble_next = 3'd0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (capture) state_next = ST_FULL;
        end
        ST_FULL: begin
          if (hazard) begin
            state_next  = ST_STALL;
            bubble_next = STALL_LOAD;
          end else if (ex_ready && !if_valid) begin
            state_next = ST_EMPTY;
          end
        end
        ST_STALL: begin
          // Leave on the cycle the counter reaches zero; FULL re-checks the hazard.
          if (bubble_reg <= 3'd1) begin
            state_next  = ST_FULL;
            bubble_next = 3'd0;
          end else begin
            bubble_next = bubble_reg - 3'd1;
          end
        end
        default: begin
          state_next  = ST_EMPTY;
          bubble_next = 3'd0;
        end
      endcase
    end
  end

  // State and bubble counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_EMPTY;
      bubble_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      bubble_reg <= bubble_next;
    end
  end

  // ID pipeline register: loads only on an accepted, unflushed fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_reg <= 4'd0;
      one_reg    <= 4'd0;
      two_reg    <= 4'd0;
      three_reg  <= 4'd0;
      imm_reg    <= IMM_NONE;
    end else if (capture) begin
      opcode_reg <= if_instr[15:12];
      one_reg    <= if_instr[11:8];
      two_reg    <= if_instr[7:4];
      three_reg  <= if_instr[3:0];
      imm_reg    <= decode_imm(if_instr[15:12]);
    end
  end

  assign id_opcode = opcode_reg;
  assign id_one    = one_reg;
  assign id_two    = two_reg;
  assign id_three  = three_reg;
  assign imm_type  = imm_reg;

`ifdef ID_STALL_PERF_EN
  logic [15:0] stall_count_reg;

  // Count every cycle spent stalled (hazard detected in FULL, or in STALL); saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_reg <= 16'd0;
    end else if ((full_hazard || (state_reg == ST_STALL)) && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed testbench for id_issue_ctrl (STALL_CYCLES = 2).
module tb_id_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        ex_load_valid;
  logic [3:0]  ex_load_dest;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_one;
  logic [3:0]  id_two;
  logic [3:0]  id_three;
  logic [1:0]  imm_type;
`ifdef ID_STALL_PERF_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  id_issue_ctrl #(.STALL_CYCLES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_ready      (if_ready),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_load_valid (ex_load_valid),
    .ex_load_dest  (ex_load_dest),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_one        (id_one),
    .id_two        (id_two),
    .id_three      (id_three),
    .imm_type      (imm_type)
`ifdef ID_STALL_PERF_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the whole ID register against an instruction word and imm class.
  task automatic chk_fields(input string tag, input logic [15:0] instr, input logic [1:0] imm);
    chk({tag, " id_valid"}, {15'd0, id_valid}, 16'd1);
    chk({tag, " fields"}, {id_opcode, id_one, id_two, id_three}, instr);
    chk({tag, " imm_type"}, {14'd0, imm_type}, {14'd0, imm});
    $display("txn %s: instr=%h imm_type=%b", tag, {id_opcode, id_one, id_two, id_three}, imm_type);
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 16'h0000; flush = 1'b0;
    ex_ready = 1'b0; ex_load_valid = 1'b0; ex_load_dest = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_valid", {15'd0, id_valid}, 16'd0);
    chk("rst fields", {id_opcode, id_one, id_two, id_three}, 16'h0000);
    chk("rst imm_type", {14'd0, imm_type}, 16'd0);
    chk("rst if_ready", {15'd0, if_ready}, 16'd1);
`ifdef ID_STALL_PERF_EN
    chk("rst stall_count", stall_count, 16'd0);
`endif
    rst_n = 1'b1;

    // Single capture, C type, latency 1
    if_valid = 1'b1; if_instr = 16'h4123; ex_ready = 1'b1;
    #1 chk("empty if_ready", {15'd0, if_ready}, 16'd1);
    tick();
    chk_fields("cap 4123", 16'h4123, 2'b10);

    // Back-to-back stream, no bubbles
    if_instr = 16'h8456;
    #1 chk("full if_ready", {15'd0, if_ready}, 16'd1);
    tick();
    chk_fields("stream 8456", 16'h8456, 2'b01);
    if_instr = 16'hC789;
    tick();
    chk_fields("stream C789", 16'hC789, 2'b11);
    if_instr = 16'h0ABC;
    tick();
    chk_fields("stream 0ABC", 16'h0ABC, 2'b00);
    if_valid = 1'b0;
    tick();
    chk("drain id_valid", {15'd0, id_valid}, 16'd0);
    chk("drain if_ready", {15'd0, if_ready}, 16'd1);

    // Load-use hazard on B type source one, 1 hazard cycle + 2 bubbles
    if_valid = 1'b1; if_instr = 16'h8356; ex_load_valid = 1'b1; ex_load_dest = 4'd3;
    tick();
    if_valid = 1'b0;
    #1;
    chk("haz c1 id_valid", {15'd0, id_valid}, 16'd0);
    chk("haz c1 if_ready", {15'd0, if_ready}, 16'd0);
    tick();
    chk("haz c2 id_valid", {15'd0, id_valid}, 16'd0);
    chk("haz c2 if_ready", {15'd0, if_ready}, 16'd0);
    ex_load_valid = 1'b0; ex_ready = 1'b0;
    tick();
    chk("haz c3 id_valid", {15'd0, id_valid}, 16'd0);
    chk("haz c3 if_ready", {15'd0, if_ready}, 16'd0);
    tick();
    chk_fields("haz c4", 16'h8356, 2'b01);
`ifdef ID_STALL_PERF_EN
    chk("perf after stall", stall_count, 16'd3);
`endif

    // EX backpressure for 4 cycles: fields hold, fetch blocked
    if_valid = 1'b1; if_instr = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold if_ready", {15'd0, if_ready}, 16'd0);
      chk_fields("hold", 16'h8356, 2'b01);
      tick();
    end
    ex_ready = 1'b1; if_instr = 16'h5678;
    #1 chk("release if_ready", {15'd0, if_ready}, 16'd1);
    tick();
    chk_fields("cap 5678", 16'h5678, 2'b10);

    // C type reads only field one: dest on field two is not a hazard
    if_valid = 1'b0; ex_ready = 1'b0; ex_load_valid = 1'b1; ex_load_dest = 4'd7;
    #1 chk("no haz on two", {15'd0, id_valid}, 16'd1);
    ex_load_dest = 4'd6;
    #1 chk("haz on one", {15'd0, id_valid}, 16'd0);
    tick();
    chk("stall id_valid", {15'd0, id_valid}, 16'd0);

    // Flush during STALL drops the same-cycle fetch
    flush = 1'b1; if_valid = 1'b1; if_instr = 16'h9ABC;
    #1 chk("stall if_ready", {15'd0, if_ready}, 16'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0; ex_load_valid = 1'b0;
    #1;
    chk("flush id_valid", {15'd0, id_valid}, 16'd0);
    chk("flush if_ready", {15'd0, if_ready}, 16'd1);
    tick();
    chk("flushed never seen", {15'd0, id_valid}, 16'd0);

    // Async reset mid-FULL between edges
    if_valid = 1'b1; if_instr = 16'hC000;
    tick();
    if_valid = 1'b0; ex_ready = 1'b0;
    chk_fields("cap C000", 16'hC000, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst id_valid", {15'd0, id_valid}, 16'd0);
    chk("async rst imm_type", {14'd0, imm_type}, 16'd0);
    chk("async rst opcode", {12'd0, id_opcode}, 16'd0);
`ifdef ID_STALL_PERF_EN
    chk("async rst stall_count", stall_count, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
Decode-stage controller for the 16-bit core. It latches fetched instructions into the ID pipeline register and splits them into opcode/one/two/three fields for the sign-extend unit and register file. It classifies the immediate type and inserts load-use stall bubbles. It also handles the valid/ready handshake between IF and EX, including flush.

Parameters:
STALL_CYCLES, 1, bubble cycles inserted per detected load-use hazard (legal 1..7)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_valid  input  1  fetch presents if_instr
if_instr  input  16  instruction: [15:12] opcode, [11:8] one, [7:4] two, [3:0] three
if_ready  output  1  ID accepts if_instr this cycle
flush  input  1  synchronous squash of ID contents (branch taken)
ex_ready  input  1  EX accepts the ID instruction this cycle
ex_load_valid  input  1  instruction in EX is a load
ex_load_dest  input  4  destination register of that load
id_valid  output  1  ID fields valid toward EX
id_opcode  output  4  registered opcode
id_one  output  4  registered field one
id_two  output  4  registered field two
id_three  output  4  registered field three
imm_type  output  2  00 none, 01 B, 10 C, 11 D

Behaviour:
- Reset (rst_n low, async): state EMPTY; id_valid=0; all field outputs, imm_type and bubble counter = 0.
- Capture: when if_valid && if_ready && !flush, the four fields and imm_type register at the clock edge. id_valid may assert the following cycle, so latency is 1 cycle.
- imm_type decode from if_opcode at capture:
  - 1000 or 1011 -> 01
  - 0100, 0101 or 0110 -> 10
  - 1100 or 1111 -> 11
  - all other opcodes -> 00
- Source registers read:
  - B types read one and two.
  - C types read one.
  - D types read none.
  - All other opcodes read two and three.
- hazard (combinational, from registered fields): ex_load_valid && ex_load_dest equals any source register read by the ID instruction.
- State EMPTY: id_valid=0, if_ready=1. Capture moves to FULL.
- State FULL, no hazard:
  - id_valid=1, if_ready=ex_ready.
  - If ex_ready and if_valid: capture the new instruction, stay FULL (back-to-back, no bubble).
  - If ex_ready and !if_valid: go to EMPTY.
  - If !ex_ready: hold all fields unchanged.
- State FULL, hazard: id_valid=0, if_ready=0. Load bubble counter with STALL_CYCLES and go to STALL.
- State STALL:
  - id_valid=0, if_ready=0.
  - Counter decrements each cycle. When it reaches 0, go to FULL.
  - The hazard is re-evaluated in FULL, so a load still held in EX re-stalls.
- Fields stay stable whenever the instruction does not advance. EX sees no field change while id_valid=0 or ex_ready=0.
- flush has the highest priority in every state:
  - Next state is EMPTY, id_valid=0 next cycle, bubble counter cleared.
  - A same-cycle if_valid is dropped, not captured.
  - Field registers keep their old values; they are don't-care while invalid.
- Simultaneous flush and ex_ready: flush wins; the current instruction is considered consumed by EX only if id_valid was 1 that cycle.
- Reset asserted mid-stall: immediate return to EMPTY, counter cleared.

Optional Feature:
ID_STALL_PERF_EN
- Defined: adds output stall_count[15:0]. It increments on every cycle in STALL or in FULL with hazard, saturates at 16'hFFFF and clears only on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then if_instr=16'h4123 (C type), if_valid=1, ex_ready=1 -> next cycle id_valid=1, id_opcode=4, id_one=1, id_two=2, id_three=3, imm_type=10.
- Stream 16'h8456, 16'hC789, 16'h0ABC on consecutive cycles with ex_ready=1 -> id_valid stays high 3 cycles; imm_type 01, 11, 00; no bubbles.
- Capture 16'h8356 with ex_load_valid=1, ex_load_dest=3, STALL_CYCLES=2 -> id_valid=0 and if_ready=0 for 3 cycles (hazard cycle + 2 bubbles). If the load has cleared, id_valid=1 on the 4th cycle with the fields unchanged.
- Hold ex_ready=0 for 4 cycles with ID FULL -> id_valid=1 and fields constant, if_ready=0. Then ex_ready=1 with if_valid=1 -> new instruction captured.
- Assert flush during STALL with if_valid=1 -> next cycle state EMPTY, id_valid=0, if_ready=1, and the flushed-cycle instruction never appears.
- Pull rst_n low mid-FULL between clock edges -> id_valid and imm_type go 0 immediately. With ID_STALL_PERF_EN defined, stall_count reads 0.
